// File: rtl/sysbus_arbiter.sv
// Round-robin owner arbiter for the shared system bus: grant, hold while busy, one turnaround cycle.
// Optional ownership watchdog enabled by defining ARB_WATCHDOG_EN.
module sysbus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int WDT_CYCLES = 64,
  parameter int WDT_WIDTH  = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_cyc,
  input  logic [NUM_REQ-1:0]   req_busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 grant_valid,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 wdt_expired
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [IDX_WIDTH-1:0] idx_next;
  logic [NUM_REQ-1:0]   grant_next;
  logic                 owned_next;
  logic [IDX_WIDTH-1:0] pick_idx;
  logic [IDX_WIDTH-1:0] cand;
  logic                 pick_found;
  logic                 wdt_fire;

  // Scan from the farthest candidate down to grant_idx+1 so the nearest requester
  // after the last owner wins, and the last owner itself comes last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = grant_idx;
    cand       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_WIDTH'((int'(grant_idx) + k) % NUM_REQ);
      if (req_cyc[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  logic [WDT_WIDTH-1:0] wdt_cnt_reg;

  // Held at zero while idle, so it starts from zero on every new ownership.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdt_cnt_reg <= '0;
    end else if (state_reg == GRANT || state_reg == BUSY) begin
      wdt_cnt_reg <= wdt_cnt_reg + 1'b1;
    end else begin
      wdt_cnt_reg <= '0;
    end
  end

  assign wdt_fire = (state_reg == GRANT || state_reg == BUSY) &&
                    (wdt_cnt_reg == WDT_WIDTH'(WDT_CYCLES - 1));
`else
  assign wdt_fire = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    idx_next   = grant_idx;
    unique case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next = GRANT;
          idx_next   = pick_idx;
        end
      end
      GRANT: begin
        if (wdt_fire)                    state_next = RELEASE;
        else if (req_busy[grant_idx])    state_next = BUSY;
        else if (!req_cyc[grant_idx])    state_next = RELEASE;
      end
      BUSY: begin
        if (wdt_fire || !req_busy[grant_idx]) state_next = RELEASE;
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    owned_next = (state_next == GRANT) || (state_next == BUSY);
    grant_next = '0;
    if (owned_next) grant_next[idx_next] = 1'b1;
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= IDX_WIDTH'(NUM_REQ - 1);
      wdt_expired <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grant       <= grant_next;
      grant_valid <= owned_next;
      grant_idx   <= idx_next;
      wdt_expired <= wdt_fire;
    end
  end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Scoreboard bench for sysbus_arbiter: expected grant order is queued by each scenario
// and popped by a monitor on every grant rise; honours ARB_WATCHDOG_EN like the RTL.
module tb_sysbus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_cyc;
  logic [3:0] req_busy;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic       wdt_expired;

  int n_checks = 0;
  int n_errors = 0;
  int sb_q[$];

  sysbus_arbiter #(
    .NUM_REQ(4), .IDX_WIDTH(2), .WDT_CYCLES(64), .WDT_WIDTH(7)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_cyc(req_cyc),
    .req_busy(req_busy),
    .grant(grant),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx),
    .wdt_expired(wdt_expired)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    req_cyc  = '0;
    req_busy = '0;
    tick();
    check("rst_grant", grant, 0);
    check("rst_valid", grant_valid, 0);
    check("rst_idx", grant_idx, 3);
    check("rst_wdt", wdt_expired, 0);
    tick();
    reset = 1'b1;
  endtask

  // Waits for the current owner (if any) to lose the grant, then for the next grant.
  task automatic wait_grant(output int idx);
    int n;
    idx = -1;
    n = 0;
    while (grant != 0 && n < 200) begin tick(); n++; end
    n = 0;
    while (grant == 0 && n < 40) begin tick(); n++; end
    if (grant == 0) check("grant_timeout", 0, 1);
    else for (int i = 0; i < 4; i++) if (grant[i]) idx = i;
  endtask

  task automatic txn(input int busy_len, input logic [3:0] req_after);
    int idx;
    wait_grant(idx);
    if (idx < 0) return;
    req_busy[idx] = 1'b1;
    repeat (busy_len) tick();
    req_busy[idx] = 1'b0;
    req_cyc = req_after;
  endtask

  task automatic drain(input string tag);
    repeat (4) tick();
    check(tag, sb_q.size(), 0);
  endtask

  // Monitor: invariants every cycle, scoreboard and turnaround gap on each grant rise.
  initial begin
    logic [3:0] prev_grant;
    bit         have_prev;
    int         gap;
    int         exp_idx;
    prev_grant = '0;
    have_prev  = 1'b0;
    gap        = 0;
    forever begin
      @(posedge clk);
      #2;
      if (reset !== 1'b1) begin
        have_prev = 1'b0;
        gap = 0;
      end else begin
        check("onehot", $onehot0(grant), 1);
        check("valid_match", grant_valid, grant != 0);
        if (grant != 0) check("idx_match", grant, 4'b0001 << grant_idx);
`ifndef ARB_WATCHDOG_EN
        check("wdt_zero", wdt_expired, 0);
`endif
        if (grant != 0 && prev_grant == 0) begin
          if (have_prev) check("gap", gap, 2);
          if (sb_q.size() == 0) begin
            check("sb_unexpected", grant, 0);
          end else begin
            exp_idx = sb_q.pop_front();
            check("grant_order", grant, 4'b0001 << exp_idx);
            $display("grant: master %0d (expected %0d) at %0t", grant_idx, exp_idx, $time);
          end
        end
        if (grant == 0) gap++;
        else begin gap = 0; have_prev = 1'b1; end
      end
      prev_grant = grant;
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    reset    = 1'b0;
    req_cyc  = '0;
    req_busy = '0;

    // Single master: grant at cycle 1, held through busy, released one cycle after busy falls.
    do_reset();
    sb_q.push_back(0);
    req_cyc = 4'b0001;
    tick();
    check("s1_grant", grant, 4'b0001);
    check("s1_idx", grant_idx, 0);
    tick();
    req_busy = 4'b0001;
    req_cyc  = 4'b0000;
    repeat (3) begin check("s1_hold", grant, 4'b0001); tick(); end
    req_busy = 4'b0000;
    check("s1_hold_last", grant, 4'b0001);
    tick();
    check("s1_release", grant, 0);
    check("s1_release_valid", grant_valid, 0);
    tick();
    check("s1_idle", grant, 0);
    drain("s1_drain");

    // Two requesters: 0 then 2.
    do_reset();
    sb_q.push_back(0); sb_q.push_back(2);
    req_cyc = 4'b0101;
    txn(3, 4'b0100);
    txn(3, 4'b0000);
    drain("s2_drain");

    // All four held: rotation 0,1,2,3,0,1.
    do_reset();
    foreach (sb_q[i]) sb_q.delete(i);
    sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(2);
    sb_q.push_back(3); sb_q.push_back(0); sb_q.push_back(1);
    req_cyc = 4'b1111;
    repeat (5) txn(2, 4'b1111);
    txn(2, 4'b0000);
    drain("s3_drain");

    // Abandoned grant: master 1 drops its request, master 3 follows after the turnaround.
    do_reset();
    sb_q.push_back(1); sb_q.push_back(3);
    req_cyc = 4'b1010;
    wait_grant(idx);
    check("s4_first", idx, 1);
    req_cyc = 4'b1000;
    tick();
    check("s4_release", grant, 0);
    tick();
    check("s4_idle", grant, 0);
    tick();
    check("s4_grant3", grant, 4'b1000);
    req_busy = 4'b1000;
    tick();
    req_busy = 4'b0000;
    req_cyc  = 4'b0000;
    drain("s4_drain");

    // Reset between edges while busy: grant vanishes at once, master 0 wins afterwards.
    do_reset();
    sb_q.push_back(0);
    req_cyc = 4'b1111;
    wait_grant(idx);
    req_busy[idx] = 1'b1;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("s5_async_grant", grant, 0);
    check("s5_async_valid", grant_valid, 0);
    tick();
    check("s5_rst_idx", grant_idx, 3);
    tick();
    req_busy = 4'b0000;
    req_cyc  = 4'b1111;
    reset    = 1'b1;
    sb_q.push_back(0); sb_q.push_back(1);
    txn(1, 4'b1111);
    txn(1, 4'b0000);
    drain("s5_drain");

    // Long ownership: cut off at 64 cycles with the watchdog, otherwise held.
    do_reset();
    sb_q.push_back(2);
    req_cyc = 4'b0100;
    wait_grant(idx);
    req_busy = 4'b0100;
    req_cyc  = 4'b0000;
    for (int k = 1; k <= 100; k++) begin
      tick();
`ifdef ARB_WATCHDOG_EN
      check("s6_grant", grant, (k < 64) ? 32'd4 : 32'd0);
      check("s6_wdt", wdt_expired, (k == 64) ? 32'd1 : 32'd0);
`else
      check("s6_hold", grant, 4'b0100);
      check("s6_wdt", wdt_expired, 0);
`endif
    end
    req_busy = 4'b0000;
    tick();
    tick();
    check("s6_final", grant, 0);
    drain("s6_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
